// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register and its step controller.
package if_id_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0;

endpackage

// File: rtl/step_ctrl.sv
// Debug single-step controller: detects step rising edges and produces the
// pipeline-register enable. Reusable by any pipeline register stage.
//
// state | meaning
// RUN   | free running, enable high
// HALT  | debug hold, enable low, waiting for a step edge
// STEP  | one enabled cycle, then back to HALT (or RUN if debug dropped)
module step_ctrl
  import if_id_pipe_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_debug_mode,
  input  logic       i_step,
  output logic       o_en,
  output logic [1:0] o_state
);

  state_t r_state;
  state_t w_state_next;
  logic   r_step_d;
  logic   w_step_rise;

  assign w_step_rise = i_step & ~r_step_d;

  // Register the step input for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_step_d <= 1'b0;
    else         r_step_d <= i_step;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_next;
  end

  // Next-state and enable decode.
  always_comb begin
    w_state_next = r_state;
    o_en         = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (i_debug_mode) w_state_next = ST_HALT;
      end
      ST_HALT: begin
        o_en = 1'b0;
        if (!i_debug_mode)    w_state_next = ST_RUN;
        else if (w_step_rise) w_state_next = ST_STEP;
      end
      ST_STEP: begin
        if (!i_debug_mode) w_state_next = ST_RUN;
        else               w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with stall, flush (bubble insertion), and debug
// single-step. Flushes requested while halted are remembered and applied on
// the next enabled cycle. Optional performance counters are built when
// IF_ID_PIPE_PERF_EN is defined.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int                NBITS     = 32,
  parameter int                NFIELDS   = 3,
  parameter int                NOP_FIELD = 2,
  parameter logic [NBITS-1:0]  NOP_WORD  = NBITS'(DEFAULT_NOP_WORD)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [NFIELDS*NBITS-1:0] i_data,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_debug_mode,
  input  logic                     i_step,
  output logic                     o_valid,
  output logic [NFIELDS*NBITS-1:0] o_data,
  output logic                     o_advance,
  output logic [1:0]               o_state
`ifdef IF_ID_PIPE_PERF_EN
  ,
  output logic [31:0]              o_stall_cnt,
  output logic [31:0]              o_flush_cnt
`endif
);

  logic                     w_en;
  logic                     w_eff_flush;
  logic                     r_pend_flush;
  logic [NFIELDS*NBITS-1:0] w_nop_data;

  step_ctrl u_step_ctrl (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_debug_mode (i_debug_mode),
    .i_step       (i_step),
    .o_en         (w_en),
    .o_state      (o_state)
  );

  assign w_eff_flush = i_flush | r_pend_flush;
  assign o_advance   = w_en & ~w_eff_flush & ~i_stall;

  // Bubble payload: only the instruction field carries the NOP encoding.
  always_comb begin
    w_nop_data = '0;
    w_nop_data[NOP_FIELD*NBITS +: NBITS] = NOP_WORD;
  end

  // Payload/valid register: flush beats stall, stall beats load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (w_en) begin
      if (w_eff_flush) begin
        o_valid <= 1'b0;
        o_data  <= w_nop_data;
      end else if (!i_stall) begin
        o_valid <= i_valid;
        o_data  <= i_data;
      end
    end
  end

  // Remember flushes that arrive while halted; consume on the next enabled cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_pend_flush <= 1'b0;
    else if (w_en)    r_pend_flush <= 1'b0;
    else if (i_flush) r_pend_flush <= 1'b1;
  end

`ifdef IF_ID_PIPE_PERF_EN
  // Saturating counters for held cycles and applied bubbles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else if (w_en) begin
      if (w_eff_flush) begin
        if (o_flush_cnt != 32'hFFFF_FFFF) o_flush_cnt <= o_flush_cnt + 32'd1;
      end else if (i_stall) begin
        if (o_stall_cnt != 32'hFFFF_FFFF) o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed testbench for if_id_pipe. Counter checks are built when
// IF_ID_PIPE_PERF_EN is defined.
`timescale 1ns/1ps
module tb_if_id_pipe;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;
  localparam logic [95:0] BUBBLE = {TB_NOP, 32'h0, 32'h0};

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [95:0] i_data;
  logic        i_stall;
  logic        i_flush;
  logic        i_debug_mode;
  logic        i_step;
  logic        o_valid;
  logic [95:0] o_data;
  logic        o_advance;
  logic [1:0]  o_state;
`ifdef IF_ID_PIPE_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_pipe #(
    .NBITS(32), .NFIELDS(3), .NOP_FIELD(2), .NOP_WORD(TB_NOP)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_debug_mode (i_debug_mode),
    .i_step       (i_step),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_advance    (o_advance),
    .o_state      (o_state)
`ifdef IF_ID_PIPE_PERF_EN
    ,
    .o_stall_cnt  (o_stall_cnt),
    .o_flush_cnt  (o_flush_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_stall = 1'b0;
    i_flush = 1'b0; i_debug_mode = 1'b0; i_step = 1'b0;
    #3;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== 96'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    tick; tick;
    i_reset = 1'b0;
    #1;
  endtask

  task automatic test_load;
    i_data = {32'h8C010004, 32'h8, 32'h4}; i_valid = 1'b1;
    #1;
    checks++; if (o_advance !== 1'b1) begin errors++; $display("FAIL load_advance got=%0b exp=1", o_advance); end
    tick;
    checks++; if (o_data !== {32'h8C010004, 32'h8, 32'h4}) begin errors++; $display("FAIL load_data got=%h", o_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL load_valid got=%0b exp=1", o_valid); end
    i_data = {32'h11112222, 32'h33334444, 32'h55556666}; i_valid = 1'b0;
    tick;
    checks++; if (o_data !== {32'h11112222, 32'h33334444, 32'h55556666}) begin errors++; $display("FAIL load2_data got=%h", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL load2_valid got=%0b exp=0", o_valid); end
    i_data = {32'h8C010004, 32'h8, 32'h4}; i_valid = 1'b1;
    tick;
  endtask

  task automatic test_stall;
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = {32'hDEAD0000 + 32'(k), 32'hBEEF, 32'h1234}; i_valid = 1'b0;
      #1;
      checks++; if (o_advance !== 1'b0) begin errors++; $display("FAIL stall_advance[%0d] got=%0b exp=0", k, o_advance); end
      tick;
      checks++; if (o_data !== {32'h8C010004, 32'h8, 32'h4} || o_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold[%0d] got=%h v=%0b", k, o_data, o_valid); end
    end
`ifdef IF_ID_PIPE_PERF_EN
    checks++; if (o_stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", o_stall_cnt); end
`endif
  endtask

  task automatic test_flush_stall;
    i_flush = 1'b1; i_stall = 1'b1;
    #1;
    checks++; if (o_advance !== 1'b0) begin errors++; $display("FAIL flush_advance got=%0b exp=0", o_advance); end
    tick;
    i_flush = 1'b0; i_stall = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== BUBBLE) begin errors++; $display("FAIL flush_data got=%h exp=%h", o_data, BUBBLE); end
`ifdef IF_ID_PIPE_PERF_EN
    checks++; if (o_flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", o_flush_cnt); end
    checks++; if (o_stall_cnt !== 32'd3) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=3", o_stall_cnt); end
`endif
  endtask

  task automatic test_step;
    i_data = {32'hA0000001, 32'h1, 32'h1}; i_valid = 1'b1; i_debug_mode = 1'b1;
    tick;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL step_halt0 got=%0d exp=1", o_state); end
    checks++; if (o_data !== {32'hA0000001, 32'h1, 32'h1}) begin errors++; $display("FAIL step_runload got=%h", o_data); end
    i_data = {32'hA0000003, 32'h3, 32'h3}; i_step = 1'b1;
    #1;
    checks++; if (o_advance !== 1'b0) begin errors++; $display("FAIL halt_advance got=%0b exp=0", o_advance); end
    tick;
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL step_state got=%0d exp=2", o_state); end
    checks++; if (o_data !== {32'hA0000001, 32'h1, 32'h1}) begin errors++; $display("FAIL halt_hold got=%h", o_data); end
    i_data = {32'hA0000004, 32'h4, 32'h4};
    #1;
    checks++; if (o_advance !== 1'b1) begin errors++; $display("FAIL step_advance got=%0b exp=1", o_advance); end
    tick;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL step_back_halt got=%0d exp=1", o_state); end
    checks++; if (o_data !== {32'hA0000004, 32'h4, 32'h4}) begin errors++; $display("FAIL step_load got=%h", o_data); end
    i_data = {32'hA0000005, 32'h5, 32'h5};
    tick; tick;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL step_held_state got=%0d exp=1", o_state); end
    checks++; if (o_data !== {32'hA0000004, 32'h4, 32'h4}) begin errors++; $display("FAIL step_once got=%h", o_data); end
    i_step = 1'b0;
  endtask

  task automatic test_pending_flush;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_data !== {32'hA0000004, 32'h4, 32'h4})
      begin errors++; $display("FAIL pend_hold got=%h v=%0b", o_data, o_valid); end
    tick;
    i_step = 1'b1;
    tick;
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL pend_step_state got=%0d exp=2", o_state); end
    #1;
    checks++; if (o_advance !== 1'b0) begin errors++; $display("FAIL pend_advance got=%0b exp=0", o_advance); end
    tick;
    checks++; if (o_valid !== 1'b0 || o_data !== BUBBLE)
      begin errors++; $display("FAIL pend_bubble got=%h v=%0b exp=%h v=0", o_data, o_valid, BUBBLE); end
`ifdef IF_ID_PIPE_PERF_EN
    checks++; if (o_flush_cnt !== 32'd2) begin errors++; $display("FAIL pend_flush_cnt got=%0d exp=2", o_flush_cnt); end
`endif
    i_step = 1'b0;
    tick;
    i_step = 1'b1; i_data = {32'hA0000006, 32'h6, 32'h6}; i_valid = 1'b1;
    tick;
    #1;
    checks++; if (o_advance !== 1'b1) begin errors++; $display("FAIL pend_cleared got=%0b exp=1", o_advance); end
    tick;
    checks++; if (o_valid !== 1'b1 || o_data !== {32'hA0000006, 32'h6, 32'h6})
      begin errors++; $display("FAIL pend_after_load got=%h v=%0b", o_data, o_valid); end
  endtask

  task automatic test_async_reset;
    i_step = 1'b0;
    tick;
    i_step = 1'b1;
    tick;
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL ar_pre_state got=%0d exp=2", o_state); end
    #2;
    i_reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== 96'h0) begin errors++; $display("FAIL ar_data got=%h exp=0", o_data); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL ar_state got=%0d exp=0", o_state); end
`ifdef IF_ID_PIPE_PERF_EN
    checks++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0)
      begin errors++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", o_stall_cnt, o_flush_cnt); end
`endif
    #1;
    i_reset = 1'b0;
    tick;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL ar_run_halt got=%0d exp=1", o_state); end
    tick;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL ar_no_step got=%0d exp=1", o_state); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_stall;
    test_flush_stall;
    test_step;
    test_pending_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameters SHALL be: NBITS, 32, width of one payload field; NFIELDS, 3, number of payload fields; NOP_FIELD, 2, index of the field that carries the instruction; NOP_WORD, 32'h0, bubble value for that field.
REQ-002 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 Port i_valid  input  1  incoming payload is a real instruction.
REQ-005 Port i_data  input  NFIELDS*NBITS  packed payload; field k occupies bits [k*NBITS +: NBITS].
REQ-006 Port i_stall  input  1  hazard unit requests hold.
REQ-007 Port i_flush  input  1  branch/jump redirect requests a bubble.
REQ-008 Port i_debug_mode  input  1  level; 1 selects single-step operation.
REQ-009 Port i_step  input  1  debug step request; its rising edge is the event.
REQ-010 Port o_valid  output  1  registered valid.
REQ-011 Port o_data  output  NFIELDS*NBITS  registered payload.
REQ-012 Port o_advance  output  1  combinational; 1 in the cycle the register loads i_data.
REQ-013 Port o_state  output  2  FSM state: 0 RUN, 1 HALT, 2 STEP.

Function
REQ-014 Enable en SHALL be 1 in RUN and STEP, 0 in HALT.
REQ-015 FSM transitions SHALL be: RUN to HALT when i_debug_mode=1; HALT to RUN when i_debug_mode=0; HALT to STEP on a step rising edge while i_debug_mode=1; STEP to HALT after one cycle, or to RUN if i_debug_mode=0.
REQ-016 The step rising edge SHALL be i_step AND NOT the registered i_step; holding i_step high SHALL yield exactly one STEP.
REQ-017 When en=1 and a flush is effective, o_valid SHALL become 0, field NOP_FIELD SHALL become NOP_WORD and all other fields SHALL become 0.
REQ-018 An effective flush SHALL be i_flush OR the pending-flush flag; it SHALL take priority over i_stall.
REQ-019 When en=1, no flush and i_stall=1, o_valid and o_data SHALL hold.
REQ-020 When en=1, no flush and i_stall=0, o_data SHALL load i_data and o_valid SHALL load i_valid, with 1-cycle latency.
REQ-021 When en=0, o_valid and o_data SHALL hold; i_flush SHALL set a pending-flush flag.
REQ-022 The pending-flush flag SHALL be applied and cleared on the next cycle with en=1.
REQ-023 o_advance SHALL equal en AND NOT effective flush AND NOT i_stall.
REQ-024 A flush and a stall in the same STEP cycle SHALL consume the step and apply the flush.

Reset
REQ-025 When i_reset is asserted, it SHALL force o_valid=0, o_data=0 (including NOP_FIELD), state RUN, the pending-flush flag 0, the registered step 0 and the counters 0, regardless of clock.
REQ-026 After reset release, the first rising edge SHALL follow REQ-015 to REQ-022; a step edge SHALL be detected only if i_step rises after release.

Configuration
REQ-027 With macro IF_ID_PIPE_PERF_EN defined, the block SHALL add outputs o_stall_cnt and o_flush_cnt, each 32 bits.
REQ-028 o_stall_cnt SHALL increment on cycles satisfying REQ-019; o_flush_cnt SHALL increment on each applied flush; both SHALL saturate at 32'hFFFFFFFF.
REQ-029 Without IF_ID_PIPE_PERF_EN, the counter ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings (RUN=2'd0, HALT=2'd1, STEP=2'd2) and the default NOP_WORD constant.
REQ-031 The step controller (edge detector plus FSM producing en) SHALL be a sub-module named step_ctrl, reusable by the other pipeline registers.

Verification
REQ-032 Scenario: reset, then i_data={32'h8C010004,32'h8,32'h4}, i_valid=1, RUN -> next cycle o_data equals the input, o_valid=1, o_advance=1.
REQ-033 Scenario: i_stall=1 for 3 cycles with changing i_data -> o_data unchanged; with PERF, o_stall_cnt=3.
REQ-034 Scenario: i_flush=1 and i_stall=1 together -> o_valid=0, field 2=NOP_WORD, fields 0 and 1 =0; with PERF, o_flush_cnt=1.
REQ-035 Scenario: i_debug_mode=1, i_step held high 5 cycles -> exactly one load, o_state sequence HALT,STEP,HALT.
REQ-036 Scenario: i_flush pulsed in HALT, then step edge -> bubble appears on the STEP cycle, then the pending flag is 0.
REQ-037 Scenario: i_reset asserted mid-STEP between clock edges -> outputs 0 and o_state=RUN immediately, before the next edge.
